// File: rtl/ble_resp_parser_if.sv
// Bus bundle between the UART RX FIFO / BLE setup controller and ble_resp_parser.
// BLE_RESP_CAPTURE_EN adds the line buffer read port (line_addr/line_byte).
interface ble_resp_parser_if #(
  parameter int LEN_W = 5
);
  logic             enable;
  logic             clear;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_rd_en;
  logic             resp_valid;
  logic [1:0]       resp_code;
  logic [LEN_W-1:0] line_len;
  logic             overflow;
  logic             busy;
`ifdef BLE_RESP_CAPTURE_EN
  logic [LEN_W-1:0] line_addr;
  logic [7:0]       line_byte;

  modport master (
    input  enable, clear, rx_valid, rx_data, line_addr,
    output rx_rd_en, resp_valid, resp_code, line_len, overflow, busy, line_byte
  );
  modport slave (
    output enable, clear, rx_valid, rx_data, line_addr,
    input  rx_rd_en, resp_valid, resp_code, line_len, overflow, busy, line_byte
  );
`else
  modport master (
    input  enable, clear, rx_valid, rx_data,
    output rx_rd_en, resp_valid, resp_code, line_len, overflow, busy
  );
  modport slave (
    output enable, clear, rx_valid, rx_data,
    input  rx_rd_en, resp_valid, resp_code, line_len, overflow, busy
  );
`endif
endinterface

// File: rtl/ble_resp_parser.sv
// Frames HM-10 response bytes from the RX FIFO into lines and classifies each as OK/ERROR/OTHER.
// Optional BLE_RESP_CAPTURE_EN keeps the last line's characters readable via line_addr/line_byte.
module ble_resp_parser #(
  parameter int LINE_MAX_LEN = 16
) (
  input logic                clk,
  input logic                rst,
  ble_resp_parser_if.master  bus
);
  localparam int LEN_W = $clog2(LINE_MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(LINE_MAX_LEN);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] POP   = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;
  localparam logic [1:0] EVAL  = 2'd3;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  localparam logic [1:0] CODE_OK    = 2'b01;
  localparam logic [1:0] CODE_ERROR = 2'b10;
  localparam logic [1:0] CODE_OTHER = 2'b11;

  logic [1:0]       state;
  logic [LEN_W-1:0] len;
  logic             ok_flag;
  logic             err_flag;
  logic             overflow_int;
  logic             is_text;

  function automatic logic ok_match(input logic [LEN_W-1:0] idx, input logic [7:0] c);
    case (idx)
      LEN_W'(0): ok_match = (c == 8'h4F);
      LEN_W'(1): ok_match = (c == 8'h4B);
      default:   ok_match = 1'b0;
    endcase
  endfunction

  function automatic logic err_match(input logic [LEN_W-1:0] idx, input logic [7:0] c);
    case (idx)
      LEN_W'(0): err_match = (c == 8'h45);
      LEN_W'(1): err_match = (c == 8'h52);
      LEN_W'(2): err_match = (c == 8'h52);
      LEN_W'(3): err_match = (c == 8'h4F);
      LEN_W'(4): err_match = (c == 8'h52);
      default:   err_match = 1'b0;
    endcase
  endfunction

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    sat_inc = (v < LEN_MAX) ? v + LEN_W'(1) : v;
  endfunction

  // Overflowed lines never match a token, even if the leading chars did.
  function automatic logic [1:0] classify(input logic [LEN_W-1:0] n, input logic ok,
                                          input logic err, input logic ovf);
    if (ovf)                                 classify = CODE_OTHER;
    else if (n == LEN_W'(2) && ok)           classify = CODE_OK;
    else if (n == LEN_W'(5) && err)          classify = CODE_ERROR;
    else                                     classify = CODE_OTHER;
  endfunction

  assign is_text      = (bus.rx_data != CHAR_CR) && (bus.rx_data != CHAR_LF);
  assign bus.rx_rd_en = (state == POP);
  assign bus.busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      len            <= '0;
      ok_flag        <= 1'b1;
      err_flag       <= 1'b1;
      overflow_int   <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_code  <= 2'b00;
      bus.line_len   <= '0;
      bus.overflow   <= 1'b0;
    end else begin
      bus.resp_valid <= 1'b0;
      if (bus.clear) begin
        state        <= IDLE;
        len          <= '0;
        ok_flag      <= 1'b1;
        err_flag     <= 1'b1;
        overflow_int <= 1'b0;
      end else begin
        case (state)
          IDLE:  if (bus.enable && bus.rx_valid) state <= POP;
          POP:   state <= LATCH;
          LATCH: begin
            if (bus.rx_data == CHAR_LF) begin
              state <= EVAL;
            end else begin
              state <= IDLE;
              if (is_text) begin
                if (!ok_match(len, bus.rx_data))  ok_flag  <= 1'b0;
                if (!err_match(len, bus.rx_data)) err_flag <= 1'b0;
                if (len == LEN_MAX) overflow_int <= 1'b1;
                len <= sat_inc(len);
              end
            end
          end
          default: begin
            if (len != '0) begin
              bus.resp_valid <= 1'b1;
              bus.resp_code  <= classify(len, ok_flag, err_flag, overflow_int);
              bus.line_len   <= len;
              bus.overflow   <= overflow_int;
            end
            state        <= IDLE;
            len          <= '0;
            ok_flag      <= 1'b1;
            err_flag     <= 1'b1;
            overflow_int <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef BLE_RESP_CAPTURE_EN
  localparam int IDX_W = $clog2(LINE_MAX_LEN);

  logic [7:0] line_buf [LINE_MAX_LEN];

  // Only text chars of the line in progress are written, so the previous line stays intact until then.
  always_ff @(posedge clk) begin
    if (!rst && !bus.clear && state == LATCH && is_text && len < LEN_MAX)
      line_buf[len[IDX_W-1:0]] <= bus.rx_data;
  end

  assign bus.line_byte = (bus.line_addr < bus.line_len) ? line_buf[bus.line_addr[IDX_W-1:0]] : 8'h00;
`endif

endmodule

// File: tb/tb_ble_resp_parser.sv
// Scoreboard bench for ble_resp_parser: FIFO model feeds bytes, a monitor checks every resp_valid.
`timescale 1ns/1ps
module tb_ble_resp_parser;
  localparam int LINE_MAX_LEN = 16;
  localparam int LEN_W = $clog2(LINE_MAX_LEN + 1);

  typedef struct packed {
    logic [1:0]       code;
    logic [LEN_W-1:0] len;
    logic             ovf;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   lf_cyc = 0;
  logic [7:0] fifo_q[$];
  resp_t      exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  ble_resp_parser_if #(.LEN_W(LEN_W)) bus ();

  ble_resp_parser #(.LINE_MAX_LEN(LINE_MAX_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) fifo_q.push_back(s[i]);
  endtask

  task automatic push_line(input string s);
    push_str(s);
    fifo_q.push_back(8'h0D);
    fifo_q.push_back(8'h0A);
  endtask

  task automatic expect_resp(input logic [1:0] code, input int len, input logic ovf);
    resp_t r;
    r.code = code;
    r.len  = LEN_W'(len);
    r.ovf  = ovf;
    exp_q.push_back(r);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((fifo_q.size() != 0 || bus.busy !== 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: actual=%0d cycles required=<2000", n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_resp_code"},  32'(bus.resp_code),  32'd0);
    check({tag, "_line_len"},   32'(bus.line_len),   32'd0);
    check({tag, "_overflow"},   32'(bus.overflow),   32'd0);
    check({tag, "_busy"},       32'(bus.busy),       32'd0);
    check({tag, "_rx_rd_en"},   32'(bus.rx_rd_en),   32'd0);
  endtask

  // FIFO model: a pop strobe seen in a cycle delivers the head byte before the next cycle.
  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.rx_rd_en === 1'b1 && fifo_q.size() > 0) begin
        bus.rx_data = fifo_q.pop_front();
        if (bus.rx_data == 8'h0A) lf_cyc = cyc;
      end
      bus.rx_valid = (fifo_q.size() != 0);
    end
  end

  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp: actual code=%0h len=%0d required=no pulse",
                   bus.resp_code, bus.line_len);
        end else begin
          e = exp_q.pop_front();
          check("resp_code", 32'(bus.resp_code), 32'(e.code));
          check("line_len",  32'(bus.line_len),  32'(e.len));
          check("overflow",  32'(bus.overflow),  32'(e.ovf));
          check("latency",   32'(cyc - lf_cyc),  32'd3);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int any_pop;
`ifdef BLE_RESP_CAPTURE_EN
    string name_s;
    logic [7:0] exp_b;
    bus.line_addr = '0;
`endif
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.clear  = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    bus.enable = 1'b1;

    push_line("OK");     expect_resp(2'b01, 2, 1'b0); drain();
    push_line("ERROR");  expect_resp(2'b10, 5, 1'b0); drain();
    push_line("OKAY");   expect_resp(2'b11, 4, 1'b0); drain();
    push_line("ERR");    expect_resp(2'b11, 3, 1'b0); drain();
    push_line("O");      expect_resp(2'b11, 1, 1'b0); drain();
    push_line("ERRORS"); expect_resp(2'b11, 6, 1'b0); drain();
    push_line("Ok");     expect_resp(2'b11, 2, 1'b0); drain();

    // Empty lines must not pulse.
    fifo_q.push_back(8'h0D); fifo_q.push_back(8'h0A);
    fifo_q.push_back(8'h0D); fifo_q.push_back(8'h0A);
    push_line("OK"); expect_resp(2'b01, 2, 1'b0); drain();

    push_line("AAAAAAAAAAAAAAAAAAAA"); expect_resp(2'b11, 16, 1'b1); drain();
    push_line("OK");                   expect_resp(2'b01, 2, 1'b0);  drain();

    // Partial line discarded by clear; held outputs stay from the last OK.
    push_str("OK"); drain();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    @(negedge clk);
    check("clear_hold_code", 32'(bus.resp_code), 32'd1);
    check("clear_hold_len",  32'(bus.line_len),  32'd2);
    push_line("ERROR"); expect_resp(2'b10, 5, 1'b0); drain();

    // Clear coinciding with POP drops the popped 'E'.
    push_str("E"); push_line("OK"); expect_resp(2'b01, 2, 1'b0);
    any_pop = 0;
    while (bus.rx_rd_en !== 1'b1 && any_pop < 100) begin
      @(negedge clk);
      any_pop++;
    end
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    drain();

    // Partial line survives an enable drop; no pops while disabled.
    push_str("ER"); drain();
    bus.enable = 1'b0;
    push_line("ROR");
    any_pop = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.rx_rd_en !== 1'b0) any_pop++;
    end
    check("no_pop_when_disabled", 32'(any_pop), 32'd0);
    check("idle_when_disabled", 32'(bus.busy), 32'd0);
    bus.enable = 1'b1;
    expect_resp(2'b10, 5, 1'b0); drain();

    push_line("AT+NAME"); expect_resp(2'b11, 7, 1'b0); drain();
`ifdef BLE_RESP_CAPTURE_EN
    name_s = "AT+NAME";
    for (int i = 0; i < 8; i++) begin
      bus.line_addr = LEN_W'(i);
      #1;
      exp_b = (i < 7) ? name_s[i] : 8'h00;
      check("line_byte", 32'(bus.line_byte), 32'(exp_b));
    end
    @(negedge clk);
`endif

    // Reset mid-line clears outputs and the partial line.
    push_str("AB"); drain();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_outputs_zero("midline_rst");
`ifdef BLE_RESP_CAPTURE_EN
    bus.line_addr = '0;
    #1;
    check("line_byte_after_rst", 32'(bus.line_byte), 32'd0);
`endif
    rst = 1'b0;
    push_line("OK"); expect_resp(2'b01, 2, 1'b0); drain();

    check("pending_expected", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
